// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated edge counter and its input conditioner.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } fm_state_t;

  // Consecutive equal samples required before the glitch filter accepts a new level
  localparam int FILTER_LEN = 3;

endpackage

// File: rtl/sig_sync_edge.sv
// Synchronizer, optional glitch filter and rising-edge detector for one async input.
// Optional filter is enabled with `define FREQ_METER_FILTER_EN.
module sig_sync_edge
  import freq_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   synced;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

`ifdef FREQ_METER_FILTER_EN
  // The filtered level doubles as the history flop, so a rise is flagged
  // in the same cycle the third matching sample arrives.
  logic [FILTER_LEN-2:0] win_q, win_d;
  logic                  filt_q, filt_d;
  logic                  all_hi, all_lo;

  always_comb begin
    win_d  = {win_q[FILTER_LEN-3:0], synced};
    all_hi = synced & (&win_q);
    all_lo = ~synced & ~(|win_q);
    filt_d = filt_q;
    if (all_hi)      filt_d = 1'b1;
    else if (all_lo) filt_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      filt_q <= filt_d;
    end
  end

  assign rise = filt_d & ~filt_q;
`else
  logic hist_q, hist_d;

  always_comb begin
    hist_d = synced;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 1'b0;
    else        hist_q <= hist_d;
  end

  assign rise = synced & ~hist_q;
`endif

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rising edges over GATE_CYCLES clk cycles.
// Build option: `define FREQ_METER_FILTER_EN adds a 3-sample glitch filter on sig_in.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 100_000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] edge_count,
  output logic             overflow
);

  localparam int               TMR_W    = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic rise;

  sig_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_in(sig_in),
    .rise  (rise)
  );

  fm_state_t        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    edge_count_d = edge_count_q;
    overflow_d   = overflow_q;
    valid_d      = valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = MEASURE;
          timer_d    = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          overflow_d = 1'b0;
          valid_d    = 1'b0;
        end else if (state_q == DONE && !valid_q) begin
          // Result is published one cycle after the gate closes
          edge_count_d = cnt_q;
          overflow_d   = ovf_q;
          valid_d      = 1'b1;
        end
      end
      MEASURE: begin
        if (rise) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_W'(1);
        end
        // Timer parks on its last value so it never wraps
        if (timer_q == TMR_LAST) state_d = DONE;
        else                     timer_d = timer_q + TMR_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      edge_count_q <= '0;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      edge_count_q <= edge_count_d;
      overflow_q   <= overflow_d;
      valid_q      <= valid_d;
    end
  end

  assign busy       = (state_q == MEASURE);
  assign valid      = valid_q;
  assign edge_count = edge_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (CNT_W=16 and CNT_W=3) share stimulus; counts checked against a sample-history model.
module tb_freq_meter;

  localparam int GATE = 100;
`ifdef FREQ_METER_FILTER_EN
  localparam int LAT        = 3;
  localparam int GLITCH_EXP = 0;
  localparam int SAT_PER    = 6;
`else
  localparam int LAT        = 1;
  localparam int GLITCH_EXP = 10;
  localparam int SAT_PER    = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic        busy, valid, overflow;
  logic [15:0] edge_count;
  logic        busy3, valid3, overflow3;
  logic [2:0]  edge_count3;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  bit samp [0:16383];

  int  per = 0, hi = 0, ph = 0;
  bit  rnd = 1'b0;
  bit  lvl = 1'b0;
  int  run_left = 0;
  int  run_max = 8;

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start),
    .busy(busy), .valid(valid), .edge_count(edge_count), .overflow(overflow)
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(3), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start),
    .busy(busy3), .valid(valid3), .edge_count(edge_count3), .overflow(overflow3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    samp[cyc[13:0]] <= sig_in;
    cyc <= cyc + 1;
  end

  // Advance one clock, then present the next waveform sample
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) begin
      if (run_left == 0) begin
        lvl = ~lvl;
        run_left = $urandom_range(3, run_max);
      end
      sig_in = lvl;
      run_left--;
    end else if (per == 0) begin
      sig_in = 1'b0;
    end else begin
      sig_in = ((ph % per) < hi);
      ph++;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue_start(output int e);
    start = 1'b1;
    step();
    e = cyc - 1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!valid && k < 400) begin
      step();
      k++;
    end
    if (!valid) k = -1;
  endtask

  // Rising edges of sig_in as seen by the counter, for a gate whose start was sampled at edge e
  function automatic int model_cnt(input int e);
    int c = 0;
    for (int n = e; n < e + GATE; n++)
      if (samp[n - LAT] == 1'b1 && samp[n - LAT - 1] == 1'b0) c++;
    return c;
  endfunction

  task automatic test_reset();
    steps(3);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b exp 0", valid); end
    n_cmp++; if (edge_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", edge_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
    rst_n = 1'b1;
    steps(5);
  endtask

  task automatic test_period10();
    int e, k, exp_c;
    per = 10; hi = 5; ph = 0;
    steps(30);
    issue_start(e);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL p10_busy got %0b exp 1", busy); end
    wait_valid(k);
    exp_c = model_cnt(e);
    n_cmp++; if (k + 1 !== 102) begin n_bad++; $display("FAIL p10_latency got %0d exp 102", k + 1); end
    n_cmp++; if (edge_count !== 16'd10) begin n_bad++; $display("FAIL p10_count got %0d exp 10", edge_count); end
    n_cmp++; if (edge_count !== exp_c[15:0]) begin n_bad++; $display("FAIL p10_model got %0d exp %0d", edge_count, exp_c); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL p10_ovf got %0b exp 0", overflow); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL p10_busy_end got %0b exp 0", busy); end
    steps(30);
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL p10_hold_valid got %0b exp 1", valid); end
    n_cmp++; if (edge_count !== exp_c[15:0]) begin n_bad++; $display("FAIL p10_hold_count got %0d exp %0d", edge_count, exp_c); end
  endtask

  task automatic test_idle_low();
    int e, k;
    per = 0;
    steps(10);
    issue_start(e);
    wait_valid(k);
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL low_valid got %0b exp 1", valid); end
    n_cmp++; if (edge_count !== 16'd0) begin n_bad++; $display("FAIL low_count got %0d exp 0", edge_count); end
    issue_start(e);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL restart_valid got %0b exp 0", valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy got %0b exp 1", busy); end
    wait_valid(k);
    n_cmp++; if (k + 1 !== 102) begin n_bad++; $display("FAIL restart_latency got %0d exp 102", k + 1); end
  endtask

  task automatic test_saturate();
    int e, k, exp_c;
    per = SAT_PER; hi = SAT_PER / 2; ph = 0;
    steps(10);
    issue_start(e);
    wait_valid(k);
    exp_c = model_cnt(e);
    n_cmp++; if (edge_count !== exp_c[15:0]) begin n_bad++; $display("FAIL sat_wide_count got %0d exp %0d", edge_count, exp_c); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL sat_wide_ovf got %0b exp 0", overflow); end
    n_cmp++; if (valid3 !== 1'b1) begin n_bad++; $display("FAIL sat_valid got %0b exp 1", valid3); end
    n_cmp++; if (edge_count3 !== 3'd7) begin n_bad++; $display("FAIL sat_count got %0d exp 7", edge_count3); end
    n_cmp++; if (overflow3 !== 1'b1) begin n_bad++; $display("FAIL sat_ovf got %0b exp 1", overflow3); end
  endtask

  task automatic test_start_ignored();
    int e, k, exp_c;
    per = 10; hi = 5; ph = 0;
    steps(10);
    issue_start(e);
    k = 1;
    while (!valid && k < 400) begin
      start = (k == 50);
      step();
      k++;
    end
    start = 1'b0;
    exp_c = model_cnt(e);
    n_cmp++; if (k !== 102) begin n_bad++; $display("FAIL ign_latency got %0d exp 102", k); end
    n_cmp++; if (edge_count !== 16'd10) begin n_bad++; $display("FAIL ign_count got %0d exp 10", edge_count); end
    n_cmp++; if (edge_count !== exp_c[15:0]) begin n_bad++; $display("FAIL ign_model got %0d exp %0d", edge_count, exp_c); end
  endtask

  task automatic test_reset_mid();
    int e, k, exp_c;
    per = 10; hi = 5; ph = 0;
    steps(5);
    issue_start(e);
    steps(39);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_pre got %0b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %0b exp 0", busy); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %0b exp 0", valid); end
    n_cmp++; if (edge_count !== 16'd0) begin n_bad++; $display("FAIL mid_count got %0d exp 0", edge_count); end
    n_cmp++; if (overflow3 !== 1'b0) begin n_bad++; $display("FAIL mid_ovf got %0b exp 0", overflow3); end
    n_cmp++; if (edge_count3 !== 3'd0) begin n_bad++; $display("FAIL mid_count3 got %0d exp 0", edge_count3); end
    steps(3);
    rst_n = 1'b1;
    steps(20);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_rst_busy got %0b exp 0", busy); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid got %0b exp 0", valid); end
    issue_start(e);
    wait_valid(k);
    exp_c = model_cnt(e);
    n_cmp++; if (k + 1 !== 102) begin n_bad++; $display("FAIL post_rst_latency got %0d exp 102", k + 1); end
    n_cmp++; if (edge_count !== exp_c[15:0]) begin n_bad++; $display("FAIL post_rst_count got %0d exp %0d", edge_count, exp_c); end
  endtask

  task automatic test_glitch();
    int e, k;
    per = 10; hi = 1; ph = 0;
    steps(20);
    issue_start(e);
    wait_valid(k);
    n_cmp++; if (edge_count !== GLITCH_EXP[15:0]) begin n_bad++; $display("FAIL glitch_count got %0d exp %0d", edge_count, GLITCH_EXP); end
    per = 0;
    steps(10);
  endtask

  task automatic test_random();
    int e, k, exp_c, sat_c;
    rnd = 1'b1; lvl = 1'b0; run_left = 5;
    for (int it = 0; it < 8; it++) begin
      run_max = $urandom_range(4, 14);
      steps($urandom_range(5, 30));
      issue_start(e);
      wait_valid(k);
      exp_c = model_cnt(e);
      sat_c = (exp_c > 7) ? 7 : exp_c;
      n_cmp++; if (edge_count !== exp_c[15:0]) begin n_bad++; $display("FAIL rnd%0d_count got %0d exp %0d", it, edge_count, exp_c); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_ovf got %0b exp 0", it, overflow); end
      n_cmp++; if (edge_count3 !== sat_c[2:0]) begin n_bad++; $display("FAIL rnd%0d_count3 got %0d exp %0d", it, edge_count3, sat_c); end
      n_cmp++; if (overflow3 !== (exp_c > 7)) begin n_bad++; $display("FAIL rnd%0d_ovf3 got %0b exp %0b", it, overflow3, exp_c > 7); end
    end
    rnd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_period10();
    test_idle_low();
    test_saturate();
    test_start_ignored();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
